dcache_repair_engine: RTL and testbench

//  Miss-repair engine sitting directly downstream of dCacheController on the arbiter side.

---
 rtl/dcache_repair_engine.sv | 135 +++++++++++++
 tb/tb_dcache_repair_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_repair_engine.sv
// Read-miss repair engine: fetches one cache line from memory as in-order beats,
// then writes the assembled line back to the cache and pulses repair_resolved.
module dcache_repair_engine #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 1024,
   parameter int BEAT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                repair_req,
   input  logic [ADDR_W-1:0]   missed_addr,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_resp_valid,
   input  logic [BEAT_W-1:0]   mem_resp_data,
   output logic                waddr_valid,
   output logic [ADDR_W-1:0]   waddr,
   output logic [LINE_W-1:0]   wdata,
   output logic [LINE_W/8-1:0] wmask,
   output logic                sent_repair,
   output logic                repair_resolved,
   output logic                busy
);

   localparam int BEATS      = LINE_W / BEAT_W;
   localparam int LINE_BYTES = LINE_W / 8;
   localparam int BEAT_BYTES = BEAT_W / 8;
   localparam int CNT_W      = $clog2(BEATS) + 1;
   localparam int IDX_W      = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_RESOLVE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]   resp_cnt_q, resp_cnt_d;
   logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
   logic [LINE_W-1:0]  line_buf_q, line_buf_d;
   logic [IDX_W-1:0]   resp_idx;
   logic               req_fire;
   logic               resp_fire;

   assign resp_idx  = resp_cnt_q[IDX_W-1:0];
   assign req_fire  = mem_req_valid && mem_req_ready;
   assign resp_fire = (state_q == S_FETCH) && mem_resp_valid && (resp_cnt_q < CNT_W'(BEATS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_cnt_q   <= '0;
         resp_cnt_q  <= '0;
         line_addr_q <= '0;
         line_buf_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_cnt_q   <= req_cnt_d;
         resp_cnt_q  <= resp_cnt_d;
         line_addr_q <= line_addr_d;
         line_buf_q  <= line_buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_cnt_d   = req_cnt_q;
      resp_cnt_d  = resp_cnt_q;
      line_addr_d = line_addr_q;
      line_buf_d  = line_buf_q;
      case (state_q)
         S_IDLE: begin
            if (repair_req) begin
               line_addr_d = missed_addr & LINE_MASK;
               req_cnt_d   = '0;
               resp_cnt_d  = '0;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            // Issue and capture are independent streams; both may advance together.
            if (req_fire) begin
               req_cnt_d = req_cnt_q + 1'b1;
            end
            if (resp_fire) begin
               line_buf_d[int'(resp_idx) * BEAT_W +: BEAT_W] = mem_resp_data;
               resp_cnt_d = resp_cnt_q + 1'b1;
               if (resp_cnt_q == CNT_W'(BEATS - 1)) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE:   state_d = S_RESOLVE;
         S_RESOLVE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid   = 1'b0;
      mem_addr        = '0;
      waddr_valid     = 1'b0;
      waddr           = '0;
      wdata           = '0;
      wmask           = '0;
      sent_repair     = 1'b0;
      repair_resolved = 1'b0;
      busy            = 1'b0;
      case (state_q)
         S_FETCH: begin
            busy          = 1'b1;
            mem_req_valid = (req_cnt_q < CNT_W'(BEATS));
            mem_addr      = line_addr_q + ADDR_W'(req_cnt_q) * ADDR_W'(BEAT_BYTES);
         end
         S_WRITE: begin
            busy        = 1'b1;
            waddr_valid = 1'b1;
            sent_repair = 1'b1;
            waddr       = line_addr_q;
            wdata       = line_buf_q;
            wmask       = '1;
         end
         S_RESOLVE: begin
            busy            = 1'b1;
            repair_resolved = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_repair_engine.sv
// Scoreboarded bench: a memory model answers beat requests, a monitor checks
// requested addresses, written lines, write latency and the resolved pulse.
module tb_dcache_repair_engine;

   logic          clk = 1'b0;
   logic          rst;
   logic          repair_req;
   logic [31:0]   missed_addr;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [31:0]   mem_addr;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;
   logic          waddr_valid;
   logic [31:0]   waddr;
   logic [1023:0] wdata;
   logic [127:0]  wmask;
   logic          sent_repair;
   logic          repair_resolved;
   logic          busy;

   dcache_repair_engine dut (
      .clk(clk), .rst(rst), .repair_req(repair_req), .missed_addr(missed_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .waddr_valid(waddr_valid), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .sent_repair(sent_repair), .repair_resolved(repair_resolved), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] due;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic [31:0] line;
      logic [31:0] seed;
      bit          lat_chk;
      logic [31:0] t_acc;
      logic [31:0] lat;
   } exp_line_t;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cyc = 0;
   logic [31:0] mem_lat = 1;
   bit          mem_toggle = 0;
   logic [31:0] mem_seed = 0;
   bit          inject_resp = 0;
   int          beats_seen = 0;
   int          resolved_cnt = 0;
   int          n_repairs = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_addr = 0;
   bit          prev_write = 0;

   resp_t       rq[$];
   logic [31:0] exp_addr_q[$];
   exp_line_t   exp_line_q[$];

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model and request-address scoreboard
   always @(negedge clk) begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (rst) begin
         rq.delete();
         mem_req_ready = 1'b0;
         prev_stall    = 1'b0;
      end else begin
         mem_req_ready = mem_toggle ? ~mem_req_ready : 1'b1;
         if (prev_stall)
            chk(mem_req_valid && (mem_addr == prev_addr), "addr_stable", mem_addr, prev_addr);
         prev_stall = mem_req_valid && !mem_req_ready;
         prev_addr  = mem_addr;
         if (mem_req_valid && mem_req_ready) begin
            if (exp_addr_q.size() == 0) begin
               chk(1'b0, "extra_req", mem_addr, 32'h0);
            end else begin
               logic [31:0] e;
               e = exp_addr_q.pop_front();
               chk(mem_addr == e, "req_addr", mem_addr, e);
            end
            rq.push_back('{cyc + 1 + mem_lat, mem_seed + ((mem_addr >> 2) & 32'h1F)});
         end
         if (inject_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
         end else if (rq.size() > 0 && rq[0].due == cyc + 1) begin
            resp_t r;
            r = rq.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = r.data;
            beats_seen++;
         end
      end
   end

   // Line-write monitor
   always @(negedge clk) begin
      if (waddr_valid) begin
         if (exp_line_q.size() == 0) begin
            chk(1'b0, "unexpected_write", waddr, 32'h0);
         end else begin
            exp_line_t e;
            int        bad;
            e = exp_line_q.pop_front();
            bad = 0;
            chk(waddr == e.line, "waddr", waddr, e.line);
            for (int k = 0; k < 32; k++) begin
               logic [31:0] w, ew;
               w  = wdata[32*k +: 32];
               ew = e.seed + 32'(k);
               if (w != ew) bad++;
               chk(w == ew, "wdata_word", w, ew);
            end
            chk($countones(wmask) == 128, "wmask_ones", 32'($countones(wmask)), 32'd128);
            chk(sent_repair, "sent_repair", {31'b0, sent_repair}, 32'd1);
            if (e.lat_chk)
               chk(cyc == e.t_acc + 32 + e.lat, "write_latency", cyc, e.t_acc + 32 + e.lat);
            $display("write line %h bad_words=%0d cycle %0d", waddr, bad, cyc);
         end
      end else begin
         if (sent_repair) chk(1'b0, "sent_without_write", 32'd1, 32'd0);
      end
      if (repair_resolved) begin
         chk(prev_write, "resolved_after_write", {31'b0, prev_write}, 32'd1);
         resolved_cnt++;
      end else if (prev_write) begin
         chk(1'b0, "resolved_missing", 32'd0, 32'd1);
      end
      prev_write = waddr_valid;
   end

   task automatic push_expect(input logic [31:0] line, input logic [31:0] seed,
                              input bit lat_chk, input logic [31:0] lat);
      for (int k = 0; k < 32; k++) exp_addr_q.push_back(line + 32'(4 * k));
      exp_line_q.push_back('{line, seed, lat_chk, cyc + 1, lat});
   endtask

   task automatic wait_resolved(input logic [31:0] alt_addr, input int alt_at);
      int n;
      n = 0;
      while (1) begin
         @(posedge clk); #1;
         n++;
         if (n == alt_at) missed_addr = alt_addr;
         if (repair_resolved) break;
         if (n > 600) begin
            chk(1'b0, "timeout_resolved", 32'(n), 32'd0);
            break;
         end
      end
      repair_req = 1'b0;
   endtask

   task automatic repair(input logic [31:0] miss, input logic [31:0] line, input logic [31:0] seed,
                         input logic [31:0] lat, input bit tog, input bit lat_chk,
                         input logic [31:0] alt_addr, input int alt_at);
      @(posedge clk); #1;
      mem_lat    = lat;
      mem_toggle = tog;
      mem_seed   = seed;
      push_expect(line, seed, lat_chk, lat);
      n_repairs++;
      missed_addr = miss;
      repair_req  = 1'b1;
      wait_resolved(alt_addr, alt_at);
      $display("repair miss %h line %h resolved at cycle %0d", miss, line, cyc);
   endtask

   initial begin
      rst           = 1'b1;
      repair_req    = 1'b0;
      missed_addr   = '0;
      mem_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk(!busy, "reset_busy", {31'b0, busy}, 32'd0);
      chk(!mem_req_valid && !waddr_valid && !repair_resolved && wdata == '0,
          "reset_outputs", {29'b0, mem_req_valid, waddr_valid, repair_resolved}, 32'd0);

      // 1: basic miss, ready=1, L=1, latency checked
      repair(32'hAABB_CCDD, 32'hAABB_CC80, 32'h1111_0000, 1, 1'b0, 1'b1, 32'hAABB_CCDD, 0);

      // 2: ready toggling, L=3
      repair(32'h4000_0A10, 32'h4000_0A00, 32'h2222_0000, 3, 1'b1, 1'b0, 32'h4000_0A10, 0);

      // 3: missed_addr changes mid-FETCH while repair_req is held
      repair(32'hAABB_CCDD, 32'hAABB_CC80, 32'h3333_0000, 2, 1'b0, 1'b1, 32'h1000_0040, 10);

      // 4: reset after 10 beats captured, then a fresh repair
      begin
         int b0, n;
         @(posedge clk); #1;
         mem_lat = 2; mem_toggle = 1'b0; mem_seed = 32'h4444_0000;
         for (int k = 0; k < 32; k++) exp_addr_q.push_back(32'h3000_0000 + 32'(4 * k));
         b0 = beats_seen;
         missed_addr = 32'h3000_0008;
         repair_req  = 1'b1;
         n = 0;
         while (beats_seen - b0 < 10 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         chk(beats_seen - b0 >= 10, "abort_beats", 32'(beats_seen - b0), 32'd10);
         rst = 1'b1;
         repair_req = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         exp_addr_q.delete();
         chk(!busy, "abort_busy", {31'b0, busy}, 32'd0);
         chk(!waddr_valid, "abort_no_write", {31'b0, waddr_valid}, 32'd0);
         repeat (5) @(posedge clk);
         #1;
         chk(!busy, "abort_idle", {31'b0, busy}, 32'd0);
      end
      repair(32'h0000_0104, 32'h0000_0100, 32'h5555_0000, 1, 1'b0, 1'b1, 32'h0000_0104, 0);

      // 5: back-to-back repairs
      repair(32'h1234_5678, 32'h1234_5600, 32'h6666_0000, 1, 1'b0, 1'b1, 32'h1234_5678, 0);
      repair(32'h2000_0000, 32'h2000_0000, 32'h7777_0000, 1, 1'b0, 1'b1, 32'h2000_0000, 0);

      // 6: stray response while IDLE
      @(posedge clk); #1;
      inject_resp = 1'b1;
      @(posedge clk); #1;
      inject_resp = 1'b0;
      chk(!busy, "stray_resp_idle", {31'b0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk(!busy, "stray_resp_still_idle", {31'b0, busy}, 32'd0);
      repair(32'h5000_00FF, 32'h5000_0080, 32'h8888_0000, 1, 1'b0, 1'b1, 32'h5000_00FF, 0);

      repeat (10) @(posedge clk);
      #1;
      chk(exp_line_q.size() == 0, "lines_outstanding", 32'(exp_line_q.size()), 32'd0);
      chk(exp_addr_q.size() == 0, "reqs_outstanding", 32'(exp_addr_q.size()), 32'd0);
      chk(resolved_cnt == n_repairs, "resolved_count", 32'(resolved_cnt), 32'(n_repairs));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
